// File: rtl/rom_arbiter_if.sv
// Request/response and ROM-side signal bundle for rom_arbiter.
// slave = the arbiter; master = the requesters together with the ROM instance.
interface rom_arbiter_if #(
    parameter int Width     = 32,
    parameter int AddrWidth = 30
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [2*AddrWidth-1:0] req_addr;
    logic [1:0]             resp_valid;
    logic [1:0]             resp_ready;
    logic [Width-1:0]       resp_data;
    logic                   resp_err;
    logic [AddrWidth-1:0]   rom_addr;
    logic [Width-1:0]       rom_data;
    logic                   rom_reset;

    modport slave (
        input  req_valid, req_addr, resp_ready, rom_data,
        output req_ready, resp_valid, resp_data, resp_err, rom_addr, rom_reset
    );

    modport master (
        output req_valid, req_addr, resp_ready, rom_data,
        input  req_ready, resp_valid, resp_data, resp_err, rom_addr, rom_reset
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one synchronous-read ROM, one read in flight at a time.
// Define ROM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module rom_arbiter #(
    parameter int Width     = 32,
    parameter int Depth     = 32,
    parameter int AddrWidth = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESP
    } state_t;

    state_t               r_state;
    logic                 r_owner;
    logic                 r_err;
    logic [AddrWidth-1:0] r_rom_addr;
    logic [1:0]           r_resp_valid;
    logic [Width-1:0]     r_resp_data;
    logic                 r_resp_err;
`ifndef ROM_ARB_FIXED_PRIO_EN
    logic                 r_last_grant;
`endif

    logic                 w_grant;
    logic                 w_accept;
    logic [AddrWidth-1:0] w_addr;

    always_comb begin
        w_grant = 1'b0;
        case (bus.req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
`ifdef ROM_ARB_FIXED_PRIO_EN
            2'b11:   w_grant = 1'b0;
`else
            2'b11:   w_grant = ~r_last_grant;
`endif
            default: w_grant = 1'b0;
        endcase
    end

    assign w_addr   = w_grant ? bus.req_addr[AddrWidth +: AddrWidth]
                              : bus.req_addr[0 +: AddrWidth];
    assign w_accept = reset_n && (r_state == IDLE) && bus.req_valid[w_grant];

    // Ready and ROM address are combinational so a request can be taken in its first cycle.
    assign bus.req_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rom_addr   = !reset_n ? '0 : (w_accept ? w_addr : r_rom_addr);
    assign bus.rom_reset  = ~reset_n;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_rom_addr   <= '0;
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant;
                        r_err        <= (w_addr >= AddrWidth'(Depth));
                        r_rom_addr   <= w_addr;
`ifndef ROM_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant;
`endif
                        r_state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // ROM output for an out-of-range address is meaningless, so it is masked.
                    r_resp_data  <= r_err ? '0 : bus.rom_data;
                    r_resp_err   <= r_err;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready[r_owner]) begin
                        r_resp_valid <= 2'b00;
                        r_resp_err   <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and ROM contents.
`timescale 1ns/1ps
module tb_rom_arbiter;
    localparam int Width     = 32;
    localparam int Depth     = 32;
    localparam int AddrWidth = 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rom_arbiter_if #(.Width(Width), .AddrWidth(AddrWidth)) bus();

    rom_arbiter #(.Width(Width), .Depth(Depth), .AddrWidth(AddrWidth)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [Width-1:0] mem [Depth];

    // ROM model: registered read; out-of-range returns junk the arbiter must mask.
    always @(posedge clk) begin
        if (bus.rom_reset)
            bus.rom_data <= '0;
        else if (bus.rom_addr < AddrWidth'(Depth))
            bus.rom_data <= mem[bus.rom_addr[4:0]];
        else
            bus.rom_data <= 32'hBAD0_BAD0;
    end

    int vectors = 0;
    int miscompares = 0;
    bit exp_last;

    function automatic logic [1:0] oh(input bit p);
        return p ? 2'b10 : 2'b01;
    endfunction

    function automatic bit exp_grant(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~exp_last;
`endif
        end
        return v[1];
    endfunction

    function automatic logic [Width-1:0] exp_data(input int a);
        return (a < Depth) ? mem[a] : '0;
    endfunction

    task automatic set_req(input int p, input int a);
        bus.req_addr[p*AddrWidth +: AddrWidth] = AddrWidth'(a);
        bus.req_valid[p] = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req_valid = 2'b00;
        set_req(0, 3);
        set_req(1, 4);
        bus.resp_ready = 2'b11;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00 ||
                bus.rom_reset !== 1'b1 || bus.rom_addr !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: req_ready=%b resp_valid=%b rom_reset=%b rom_addr=%0d, want 00 00 1 0",
                         bus.req_ready, bus.resp_valid, bus.rom_reset, bus.rom_addr);
            end
        end
        cyc();
        reset_n = 1'b1;
        exp_last = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b01 || bus.rom_addr !== AddrWidth'(3) || bus.rom_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_grant: req_ready=%b rom_addr=%0d rom_reset=%b, want 01 3 0",
                     bus.req_ready, bus.rom_addr, bus.rom_reset);
        end
        cyc();
        bus.req_valid[0] = 1'b0;
        exp_last = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_capture_ready: req_ready=%b, want 00", bus.req_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 2'b01 || bus.resp_data !== mem[3]) begin
            miscompares++;
            $display("FAIL reset_first_resp: resp_valid=%b data=%h, want 01 %h",
                     bus.resp_valid, bus.resp_data, mem[3]);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_second_grant: req_ready=%b, want 10", bus.req_ready);
        end
        cyc();
        bus.req_valid[1] = 1'b0;
        exp_last = 1'b1;
        drain();
        $display("reset test done");
    endtask

    task automatic test_single_read();
        bus.resp_ready = 2'b11;
        set_req(0, 5);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b01 || bus.rom_addr !== AddrWidth'(5)) begin
            miscompares++;
            $display("FAIL single_accept: req_ready=%b rom_addr=%0d, want 01 5", bus.req_ready, bus.rom_addr);
        end
        cyc();
        bus.req_valid[0] = 1'b0;
        exp_last = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_early_resp: resp_valid=%b, want 00", bus.resp_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'hDEADBEEF || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_resp: resp_valid=%b data=%h err=%b, want 01 deadbeef 0",
                     bus.resp_valid, bus.resp_data, bus.resp_err);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_resp_clear: resp_valid=%b, want 00", bus.resp_valid);
        end
        $display("single read addr 5 done");
        drain();
    endtask

    task automatic test_collision();
        bit g;
        bus.resp_ready = 2'b11;
        set_req(0, 1);
        set_req(1, 2);
        for (int t = 0; t < 4; t++) begin
            g = exp_grant(2'b11);
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== oh(g)) begin
                miscompares++;
                $display("FAIL collision_grant[%0d]: req_ready=%b, want %b", t, bus.req_ready, oh(g));
            end
            cyc();
            exp_last = g;
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if (bus.resp_valid !== oh(g) || bus.resp_data !== mem[g ? 2 : 1]) begin
                miscompares++;
                $display("FAIL collision_resp[%0d]: resp_valid=%b data=%h, want %b %h",
                         t, bus.resp_valid, bus.resp_data, oh(g), mem[g ? 2 : 1]);
            end
            $display("collision txn %0d granted port %0d", t, g);
            cyc();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int a;
        a = $urandom_range(0, Depth - 1);
        bus.resp_ready = 2'b11;
        set_req(1, a);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_accept: req_ready=%b, want 10", bus.req_ready);
        end
        cyc();
        exp_last = 1'b1;
        bus.req_valid[1] = 1'b0;
        set_req(0, 7);
        bus.resp_ready = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.resp_valid !== 2'b10 || bus.resp_data !== mem[a] || bus.req_ready !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: resp_valid=%b data=%h req_ready=%b, want 10 %h 00",
                         k, bus.resp_valid, bus.resp_data, bus.req_ready, mem[a]);
            end
        end
        cyc();
        bus.resp_ready = 2'b11;
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 2'b10 || bus.req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_release_cycle: resp_valid=%b req_ready=%b, want 10 00", bus.resp_valid, bus.req_ready);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b01 || bus.resp_valid !== 2'b00 || bus.rom_addr !== AddrWidth'(7)) begin
            miscompares++;
            $display("FAIL bp_next_accept: req_ready=%b resp_valid=%b rom_addr=%0d, want 01 00 7",
                     bus.req_ready, bus.resp_valid, bus.rom_addr);
        end
        cyc();
        bus.req_valid[0] = 1'b0;
        exp_last = 1'b0;
        $display("backpressure on port 1 addr %0d done", a);
        drain();
    endtask

    task automatic test_out_of_range();
        int addrs [3];
        addrs[0] = Depth - 1;
        addrs[1] = Depth;
        addrs[2] = int'($urandom_range(Depth + 1, 1000000));
        bus.resp_ready = 2'b11;
        for (int t = 0; t < 3; t++) begin
            set_req(1, addrs[t]);
            @(negedge clk);
            cyc();
            bus.req_valid[1] = 1'b0;
            exp_last = 1'b1;
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if (bus.resp_valid !== 2'b10 || bus.resp_err !== (addrs[t] >= Depth) ||
                bus.resp_data !== exp_data(addrs[t])) begin
                miscompares++;
                $display("FAIL range[%0d]: resp_valid=%b err=%b data=%h, want 10 %b %h",
                         addrs[t], bus.resp_valid, bus.resp_err, bus.resp_data,
                         (addrs[t] >= Depth), exp_data(addrs[t]));
            end
            $display("range read addr %0d done", addrs[t]);
            drain();
        end
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 2'b11;
        set_req(0, 9);
        @(negedge clk);
        cyc();
        bus.req_valid[0] = 1'b0;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        exp_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.resp_valid !== 2'b00 || bus.resp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_no_resp[%0d]: resp_valid=%b err=%b, want 00 0",
                         k, bus.resp_valid, bus.resp_err);
            end
        end
        cyc();
        set_req(1, 4);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_idle: req_ready=%b, want 10", bus.req_ready);
        end
        cyc();
        bus.req_valid[1] = 1'b0;
        exp_last = 1'b1;
        $display("reset during capture done");
        drain();
    endtask

    task automatic test_random();
        bit pend [2];
        int paddr [2];
        bit g;
        int delay;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
                    pend[p] = 1'b1;
                    paddr[p] = $urandom_range(0, Depth + 8);
                    set_req(p, paddr[p]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1;
                paddr[0] = $urandom_range(0, Depth + 8);
                set_req(0, paddr[0]);
            end
            g = exp_grant({pend[1], pend[0]});
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== oh(g) || bus.rom_addr !== AddrWidth'(paddr[g])) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: req_ready=%b rom_addr=%0d, want %b %0d",
                         t, bus.req_ready, bus.rom_addr, oh(g), paddr[g]);
            end
            $display("rand txn %0d: valid=%b last=%0d grant=%0d addr=%0d",
                     t, {pend[1], pend[0]}, exp_last, g, paddr[g]);
            cyc();
            pend[g] = 1'b0;
            bus.req_valid[g] = 1'b0;
            exp_last = g;
            bus.resp_ready[~g] = 1'($urandom_range(0, 1));
            bus.resp_ready[g] = 1'b0;
            delay = $urandom_range(0, 3);
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL rand_capture[%0d]: req_ready=%b resp_valid=%b, want 00 00",
                         t, bus.req_ready, bus.resp_valid);
            end
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk);
                vectors++;
                if (bus.resp_valid !== oh(g) || bus.resp_data !== exp_data(paddr[g]) ||
                    bus.resp_err !== (paddr[g] >= Depth) || bus.req_ready !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rand_resp[%0d.%0d]: resp_valid=%b data=%h err=%b req_ready=%b, want %b %h %b 00",
                             t, k, bus.resp_valid, bus.resp_data, bus.resp_err, bus.req_ready,
                             oh(g), exp_data(paddr[g]), (paddr[g] >= Depth));
                end
                if (k == delay) bus.resp_ready[g] = 1'b1;
            end
            cyc();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        bus.req_valid  = 2'b00;
        bus.req_addr   = '0;
        bus.resp_ready = 2'b00;
        exp_last = 1'b1;
        test_reset();
        test_single_read();
        test_collision();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer that shares one single-port, synchronous-read instruction/data ROM between two requesters: port 0 (instruction fetch) and port 1 (data load). It accepts one read at a time over a valid/ready handshake, drives the ROM address and reset, captures the one-cycle-latency ROM output, and returns it to the owning port over a valid/ready response channel. Out-of-range addresses are flagged. The block sits between the core's fetch/load units and the ROM instance.

## Interface
- Width, 32, ROM word width in bits
- Depth, 32, number of ROM words; valid addresses are 0..Depth-1
- AddrWidth, 30, word-address width
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- req_valid  in  2  bit i: port i presents a read request
- req_ready  out  2  bit i: port i's request is accepted this cycle
- req_addr  in  2*AddrWidth  port i's word address at bits [i*AddrWidth +: AddrWidth]
- resp_valid  out  2  one-hot; bit i: response for port i is on resp_data/resp_err
- resp_ready  in  2  bit i: port i consumes its response
- resp_data  out  Width  read data, shared by both ports
- resp_err  out  1  the accepted address was >= Depth; resp_data is 0
- rom_addr  out  AddrWidth  ROM address
- rom_data  in  Width  ROM registered read data, one cycle after rom_addr
- rom_reset  out  1  active-high ROM reset, equal to ~reset_n

## Operation
- FSM states: IDLE, CAPTURE, RESP.
- IDLE: grant is computed combinationally from req_valid.
  - If exactly one port is valid, that port is granted.
  - If both ports are valid, the port that was not granted last is granted (round-robin).
  - req_ready[grant] = 1 only when req_valid[grant] = 1.
  - rom_addr = req_addr of the granted port. With no request, rom_addr holds its last value.
  - On handshake: the address, the grant id, and err = (addr >= Depth) are registered; last_grant is updated; next state is CAPTURE.
- CAPTURE: req_ready = 0. rom_data is latched into the resp_data register; it is forced to 0 if err is set. Next state is RESP.
- RESP: resp_valid[owner] = 1 and resp_err = err; resp_data is held stable. When resp_ready[owner] = 1, next state is IDLE. resp_ready of the non-owner is ignored.
- Only one transaction is outstanding. Both req_ready bits are 0 outside IDLE.
- Requester rule: once req_valid[i] is asserted, it must not drop and req_addr must not change until req_ready[i] is seen. The arbiter does not check this.
- Round-robin pointer last_grant resets to 1, so port 0 wins the first collision.
- Reset (reset_n = 0 at any edge, including mid-transaction):
  - State returns to IDLE; any pending response is discarded and never presented.
  - Outputs: req_ready = 0, resp_valid = 0, resp_data = 0, resp_err = 0, rom_addr = 0.
  - rom_reset = 1 combinationally while reset_n = 0.

## Timing
- Request accepted at edge N.
- ROM samples rom_addr at edge N; rom_data is valid during cycle N+1.
- Data captured at edge N+1; resp_valid is high from cycle N+2.
- Accept-to-response latency: 2 cycles.
- A response accepted at edge M returns the FSM to IDLE; the earliest next request acceptance is edge M+1.
- Peak throughput: 1 read per 3 cycles.
- A combinational path exists from req_valid to req_ready and to rom_addr. No path exists from resp_ready to any output in the same cycle.

## Configuration
- ROM_ARB_FIXED_PRIO_EN defined: on collision, port 0 always wins; last_grant is not used. Port 1 may starve.
- ROM_ARB_FIXED_PRIO_EN undefined (default): round-robin arbitration as described in Operation.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles with both req_valid = 1 -> req_ready = 0, resp_valid = 0, rom_reset = 1, rom_addr = 0. Release -> port 0 is granted first.
- Single read: port 0 reads addr 5 (ROM[5] = 0xDEADBEEF), resp_ready held at 1 -> resp_valid = 2'b01 two cycles after accept, resp_data = 0xDEADBEEF, resp_err = 0.
- Collision fairness: both ports continuously valid (addr 1 and addr 2) for 4 transactions -> grants alternate 0,1,0,1 with matching data. With ROM_ARB_FIXED_PRIO_EN defined -> grants are 0,0,0,0.
- Backpressure: resp_ready[1] = 0 for 5 cycles -> resp_data and resp_valid stay stable, req_ready stays 0, and the pending port-0 request waits. Next acceptance is the cycle after the resp_ready[1] = 1 edge.
- Out of range: port 1 reads addr Depth (32) -> resp_err = 1 and resp_data = 0.
- Reset mid-operation: assert reset_n = 0 during CAPTURE -> no resp_valid is ever produced for that request, and the FSM is in IDLE after release.
